lsu_ctrl: RTL and testbench
===========================

Name: lsu_ctrl

Overview:
Parametrised load/store unit for the MEM stage. It replaces the fixed-width, single-cycle DPI access with a valid/ready request, a bus transaction that may take several cycles, and a registered response. It byte-lane aligns store data and write masks and extracts and sign/zero-extends load data from any naturally aligned address. Misaligned accesses and bus timeouts are reported as errors instead of being issued.

Parameters:
XLEN, 64, data/address width; must be 32 or 64; bus beat = XLEN/8 bytes
TIMEOUT_CYC, 255, max cycles in WAIT before error; 0 disables timeout
CNT_W, 8, width of timeout counter; must be ≥ clog2(TIMEOUT_CYC+1)

Ports:
clk  in  1  clock; all logic on posedge
rst  in  1  synchronous reset, active-high
req_valid  in  1  pipeline request valid
req_ready  out  1  unit can accept request
req_is_store  in  1  1=store, 0=load
req_size  in  2  0=byte, 1=half, 2=word, 3=dword (3 illegal when XLEN=32)
req_unsigned  in  1  zero-extend load result
req_addr  in  XLEN  byte address
req_wdata  in  XLEN  store data, LSB-justified
mem_req_valid  out  1  bus request valid
mem_req_ready  in  1  bus accepts request
mem_req_we  out  1  bus write
mem_req_addr  out  XLEN  beat-aligned address (low log2(XLEN/8) bits zero)
mem_req_wdata  out  XLEN  lane-shifted store data
mem_req_wmask  out  XLEN/8  byte-lane write mask; all-zero for loads
mem_rsp_valid  in  1  bus response (read data or write ack)
mem_rsp_rdata  in  XLEN  full beat read data
rsp_valid  out  1  result valid
rsp_ready  in  1  pipeline accepts result
rsp_data  out  XLEN  extended load result; 0 for stores and errors
rsp_err  out  1  misaligned, illegal size, or timeout

Behaviour:
- Clock: single clock clk. Reset: rst, synchronous, active-high.
- Reset values: state=IDLE; req_ready=1; mem_req_valid=0; rsp_valid=0; rsp_data=0; rsp_err=0; timeout counter=0; all mem_req_* data outputs 0.
- FSM states: IDLE, REQ, WAIT, RESP.
- IDLE: req_ready=1. On req_valid, latch the request fields.
  - Misaligned (addr mod 2^size ≠ 0) or illegal size → RESP with err=1; no bus traffic.
  - Otherwise → REQ.
- REQ: mem_req_valid=1, outputs registered and held stable until mem_req_ready.
  - Handshake when mem_req_valid & mem_req_ready → WAIT, counter cleared.
  - A mem_rsp_valid in the same cycle as the handshake is ignored; responses arrive at least one cycle later.
- WAIT: on mem_rsp_valid, compute rsp_data → RESP.
  - Otherwise increment the counter. If TIMEOUT_CYC≠0 and counter reaches TIMEOUT_CYC → RESP with err=1.
- RESP: rsp_valid=1, data/err held until rsp_ready, then → IDLE. req_ready=0 in every non-IDLE state. Minimum request-to-response latency: 3 cycles (IDLE→REQ→WAIT→RESP).
- Lane offset: off = addr[log2(XLEN/8)-1:0].
  - wdata = req_wdata << (8·off).
  - wmask = ((1<<2^size)-1) << off.
- Load result: shifted = mem_rsp_rdata >> (8·off); take the low 8·2^size bits, then sign-extend (req_unsigned=0) or zero-extend. Size 3 is passed through unchanged.
- Store: rsp_data=0 and the response fires on the write ack.
- rst asserted in any state: return to IDLE next cycle and drop mem_req_valid/rsp_valid. A late mem_rsp_valid arriving in IDLE is ignored.
- No request queueing: only one transaction is outstanding at a time.

Test Plan:
1. Reset mid-WAIT: rst for 1 cycle during WAIT → next cycle state IDLE, req_ready=1, rsp_valid=0; a later mem_rsp_valid is ignored and produces no rsp_valid.
2. LB, addr=0x8000_0003, signed, rdata=0x0000_0000_8000_0000 → mem_req_addr=0x8000_0000, wmask=0x00, rsp_data=0xFFFF_FFFF_FFFF_FF80, err=0. Same access with LBU → rsp_data=0x80.
3. SH, addr=0x1006, wdata=0xABCD → wdata=0xABCD_0000_0000_0000, wmask=0xC0, mem_req_we=1; ack → rsp_valid, rsp_data=0.
4. LW, addr=0x1002 → rsp_err=1 after 1 cycle, mem_req_valid never asserts.
5. Backpressure: mem_req_ready low 5 cycles, then rsp_ready low 3 cycles → request and response fields stable throughout; exactly one handshake on each interface.
6. TIMEOUT_CYC=4, no mem_rsp_valid → rsp_err=1 four cycles after entering WAIT. XLEN=32 with size=3 → err=1.

Source files
------------

// File: rtl/lsu_ctrl.sv
// Load/store unit for the MEM stage: one outstanding bus transaction at a time.
// It lane-aligns store data and masks, and extracts and extends load data.
module lsu_ctrl #(
  parameter int XLEN        = 64,
  parameter int TIMEOUT_CYC = 255,
  parameter int CNT_W       = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_is_store,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [XLEN-1:0]   req_addr,
  input  logic [XLEN-1:0]   req_wdata,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic              mem_req_we,
  output logic [XLEN-1:0]   mem_req_addr,
  output logic [XLEN-1:0]   mem_req_wdata,
  output logic [XLEN/8-1:0] mem_req_wmask,
  input  logic              mem_rsp_valid,
  input  logic [XLEN-1:0]   mem_rsp_rdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [XLEN-1:0]   rsp_data,
  output logic              rsp_err
);
  localparam int MASK_W  = XLEN / 8;
  localparam int OFF_W   = $clog2(MASK_W);
  localparam int TO_LAST = (TIMEOUT_CYC == 0) ? 0 : TIMEOUT_CYC - 1;

  typedef enum logic [1:0] {IDLE, REQ, WAIT, RESP} state_t;
  state_t state, state_nxt;

  logic [1:0]       size_p0;
  logic             uns_p0;
  logic [OFF_W-1:0] off_p0;
  logic [CNT_W-1:0] cnt;
  logic             req_bad;
  logic             timeout_hit;

  function automatic logic is_misaligned(input logic [2:0] lo, input logic [1:0] size);
    case (size)
      2'd0:    return 1'b0;
      2'd1:    return lo[0];
      2'd2:    return |lo[1:0];
      default: return |lo;
    endcase
  endfunction

  function automatic logic [MASK_W-1:0] lane_mask(input logic [1:0] size, input logic [OFF_W-1:0] off);
    logic [7:0] m;
    case (size)
      2'd0:    m = 8'h01;
      2'd1:    m = 8'h03;
      2'd2:    m = 8'h0F;
      default: m = 8'hFF;
    endcase
    return MASK_W'(m) << off;
  endfunction

  // Shift the addressed lanes down, then sign- or zero-extend to XLEN.
  function automatic logic [XLEN-1:0] load_ext(input logic [XLEN-1:0] rdata, input logic [OFF_W-1:0] off,
                                               input logic [1:0] size, input logic uns);
    logic [XLEN-1:0]        sh;
    logic [XLEN-1:0]        zx;
    logic signed [XLEN-1:0] sx;
    logic signed [7:0]      b;
    logic signed [15:0]     h;
    logic signed [31:0]     w;
    sh = rdata >> {off, 3'b000};
    b  = sh[7:0];
    h  = sh[15:0];
    w  = sh[31:0];
    case (size)
      2'd0:    begin sx = XLEN'(b); zx = XLEN'(sh[7:0]);  end
      2'd1:    begin sx = XLEN'(h); zx = XLEN'(sh[15:0]); end
      2'd2:    begin sx = XLEN'(w); zx = XLEN'(sh[31:0]); end
      default: begin sx = sh;       zx = sh;              end
    endcase
    return uns ? zx : XLEN'(sx);
  endfunction

  assign req_bad     = is_misaligned(req_addr[2:0], req_size) || (XLEN == 32 && req_size == 2'd3);
  assign timeout_hit = (TIMEOUT_CYC != 0) && (cnt == CNT_W'(TO_LAST));

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt     = state;
    req_ready     = 1'b0;
    mem_req_valid = 1'b0;
    rsp_valid     = 1'b0;
    case (state)
      IDLE: begin
        req_ready = 1'b1;
        if (req_valid) state_nxt = req_bad ? RESP : REQ;
      end
      REQ: begin
        mem_req_valid = 1'b1;
        if (mem_req_ready) state_nxt = WAIT;
      end
      WAIT: if (mem_rsp_valid || timeout_hit) state_nxt = RESP;
      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Request capture and response formation
  always_ff @(posedge clk) begin
    if (rst) begin
      size_p0       <= '0;
      uns_p0        <= 1'b0;
      off_p0        <= '0;
      cnt           <= '0;
      mem_req_we    <= 1'b0;
      mem_req_addr  <= '0;
      mem_req_wdata <= '0;
      mem_req_wmask <= '0;
      rsp_data      <= '0;
      rsp_err       <= 1'b0;
    end else begin
      case (state)
        IDLE: if (req_valid) begin
          size_p0 <= req_size;
          uns_p0  <= req_unsigned;
          off_p0  <= req_addr[OFF_W-1:0];
          if (req_bad) begin
            rsp_data <= '0;
            rsp_err  <= 1'b1;
          end else begin
            mem_req_we    <= req_is_store;
            mem_req_addr  <= {req_addr[XLEN-1:OFF_W], {OFF_W{1'b0}}};
            mem_req_wdata <= req_is_store ? (req_wdata << {req_addr[OFF_W-1:0], 3'b000}) : '0;
            mem_req_wmask <= req_is_store ? lane_mask(req_size, req_addr[OFF_W-1:0]) : '0;
          end
        end
        REQ: if (mem_req_ready) cnt <= '0;
        WAIT: begin
          if (mem_rsp_valid) begin
            rsp_err  <= 1'b0;
            rsp_data <= mem_req_we ? '0 : load_ext(mem_rsp_rdata, off_p0, size_p0, uns_p0);
          end else begin
            cnt <= cnt + 1'b1;
            if (timeout_hit) begin
              rsp_err  <= 1'b1;
              rsp_data <= '0;
            end
          end
        end
        default: ;
      endcase
    end
  end
endmodule

// File: tb/tb_lsu_ctrl.sv
// Directed bench for lsu_ctrl: a 64-bit instance for datapath/backpressure
// cases and a 32-bit instance with a short timeout.
module tb_lsu_ctrl;
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        a_req_valid, a_req_ready, a_req_is_store, a_req_unsigned;
  logic [1:0]  a_req_size;
  logic [63:0] a_req_addr, a_req_wdata;
  logic        a_mem_req_valid, a_mem_req_ready, a_mem_req_we;
  logic [63:0] a_mem_req_addr, a_mem_req_wdata;
  logic [7:0]  a_mem_req_wmask;
  logic        a_mem_rsp_valid;
  logic [63:0] a_mem_rsp_rdata;
  logic        a_rsp_valid, a_rsp_ready, a_rsp_err;
  logic [63:0] a_rsp_data;

  logic        b_req_valid, b_req_ready, b_req_is_store, b_req_unsigned;
  logic [1:0]  b_req_size;
  logic [31:0] b_req_addr, b_req_wdata;
  logic        b_mem_req_valid, b_mem_req_ready, b_mem_req_we;
  logic [31:0] b_mem_req_addr, b_mem_req_wdata;
  logic [3:0]  b_mem_req_wmask;
  logic        b_mem_rsp_valid;
  logic [31:0] b_mem_rsp_rdata;
  logic        b_rsp_valid, b_rsp_ready, b_rsp_err;
  logic [31:0] b_rsp_data;

  lsu_ctrl #(.XLEN(64), .TIMEOUT_CYC(255), .CNT_W(8)) u_a (
    .clk(clk), .rst(rst),
    .req_valid(a_req_valid), .req_ready(a_req_ready), .req_is_store(a_req_is_store),
    .req_size(a_req_size), .req_unsigned(a_req_unsigned), .req_addr(a_req_addr),
    .req_wdata(a_req_wdata),
    .mem_req_valid(a_mem_req_valid), .mem_req_ready(a_mem_req_ready), .mem_req_we(a_mem_req_we),
    .mem_req_addr(a_mem_req_addr), .mem_req_wdata(a_mem_req_wdata), .mem_req_wmask(a_mem_req_wmask),
    .mem_rsp_valid(a_mem_rsp_valid), .mem_rsp_rdata(a_mem_rsp_rdata),
    .rsp_valid(a_rsp_valid), .rsp_ready(a_rsp_ready), .rsp_data(a_rsp_data), .rsp_err(a_rsp_err)
  );

  lsu_ctrl #(.XLEN(32), .TIMEOUT_CYC(4), .CNT_W(8)) u_b (
    .clk(clk), .rst(rst),
    .req_valid(b_req_valid), .req_ready(b_req_ready), .req_is_store(b_req_is_store),
    .req_size(b_req_size), .req_unsigned(b_req_unsigned), .req_addr(b_req_addr),
    .req_wdata(b_req_wdata),
    .mem_req_valid(b_mem_req_valid), .mem_req_ready(b_mem_req_ready), .mem_req_we(b_mem_req_we),
    .mem_req_addr(b_mem_req_addr), .mem_req_wdata(b_mem_req_wdata), .mem_req_wmask(b_mem_req_wmask),
    .mem_rsp_valid(b_mem_rsp_valid), .mem_rsp_rdata(b_mem_rsp_rdata),
    .rsp_valid(b_rsp_valid), .rsp_ready(b_rsp_ready), .rsp_data(b_rsp_data), .rsp_err(b_rsp_err)
  );

  int n_cmp = 0;
  int n_bad = 0;
  int a_mem_hs = 0;
  int a_rsp_hs = 0;

  always @(posedge clk) begin
    if (a_mem_req_valid && a_mem_req_ready) a_mem_hs <= a_mem_hs + 1;
    if (a_rsp_valid && a_rsp_ready)         a_rsp_hs <= a_rsp_hs + 1;
  end

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed %h, expected %h", tag, obs, exp);
    end
  endtask

  task automatic a_load(input string tag, input logic [63:0] addr, input logic [1:0] size,
                        input logic uns, input logic [63:0] rdata, input logic [63:0] exp);
    a_req_valid = 1'b1; a_req_is_store = 1'b0; a_req_size = size;
    a_req_unsigned = uns; a_req_addr = addr; a_mem_req_ready = 1'b1;
    tick;
    a_req_valid = 1'b0;
    chk({tag, "_maddr"}, a_mem_req_addr, addr & ~64'h7);
    chk({tag, "_wmask"}, a_mem_req_wmask, 0);
    tick;
    a_mem_req_ready = 1'b0; a_mem_rsp_valid = 1'b1; a_mem_rsp_rdata = rdata;
    tick;
    a_mem_rsp_valid = 1'b0;
    chk({tag, "_vld"}, a_rsp_valid, 1);
    chk({tag, "_data"}, a_rsp_data, exp);
    chk({tag, "_err"}, a_rsp_err, 0);
    tick;
  endtask

  int hs_mem0, hs_rsp0;

  initial begin
    rst = 1'b1;
    a_req_valid = 0; a_req_is_store = 0; a_req_size = 0; a_req_unsigned = 0;
    a_req_addr = 0; a_req_wdata = 0; a_mem_req_ready = 0; a_mem_rsp_valid = 0;
    a_mem_rsp_rdata = 0; a_rsp_ready = 1;
    b_req_valid = 0; b_req_is_store = 0; b_req_size = 0; b_req_unsigned = 0;
    b_req_addr = 0; b_req_wdata = 0; b_mem_req_ready = 0; b_mem_rsp_valid = 0;
    b_mem_rsp_rdata = 0; b_rsp_ready = 1;
    tick; tick;
    rst = 1'b0;

    chk("rst_req_ready", a_req_ready, 1);
    chk("rst_mreq_valid", a_mem_req_valid, 0);
    chk("rst_rsp_valid", a_rsp_valid, 0);
    chk("rst_rsp_data", a_rsp_data, 0);
    chk("rst_rsp_err", a_rsp_err, 0);
    chk("rst_mreq_addr", a_mem_req_addr, 0);
    chk("rst_mreq_wmask", a_mem_req_wmask, 0);
    chk("rst_b_req_ready", b_req_ready, 1);

    // Reset while waiting for the bus response
    a_req_valid = 1; a_req_size = 2; a_req_addr = 64'h100; a_mem_req_ready = 1;
    tick;
    a_req_valid = 0;
    chk("t1_mreq_valid", a_mem_req_valid, 1);
    tick;
    chk("t1_wait_mreq_valid", a_mem_req_valid, 0);
    chk("t1_wait_req_ready", a_req_ready, 0);
    a_mem_req_ready = 0; rst = 1;
    tick;
    rst = 0;
    chk("t1_idle_req_ready", a_req_ready, 1);
    chk("t1_idle_rsp_valid", a_rsp_valid, 0);
    a_mem_rsp_valid = 1; a_mem_rsp_rdata = 64'h55;
    tick;
    a_mem_rsp_valid = 0;
    chk("t1_late_rsp_valid", a_rsp_valid, 0);
    chk("t1_late_req_ready", a_req_ready, 1);
    tick;
    chk("t1_late_rsp_valid2", a_rsp_valid, 0);

    // Loads: extraction and extension
    a_load("lb", 64'h8000_0003, 0, 0, 64'h0000_0000_8000_0000, 64'hFFFF_FFFF_FFFF_FF80);
    a_load("lbu", 64'h8000_0003, 0, 1, 64'h0000_0000_8000_0000, 64'h0000_0000_0000_0080);
    a_load("lh", 64'h1002, 1, 0, 64'h0000_0000_7FFF_0000, 64'h0000_0000_0000_7FFF);
    a_load("lw", 64'h1004, 2, 0, 64'h8765_4321_0000_0000, 64'hFFFF_FFFF_8765_4321);
    a_load("lwu", 64'h1004, 2, 1, 64'h8765_4321_0000_0000, 64'h0000_0000_8765_4321);
    a_load("ld", 64'h2000, 3, 0, 64'hDEAD_BEEF_CAFE_F00D, 64'hDEAD_BEEF_CAFE_F00D);

    // Halfword store in the top lanes
    a_req_valid = 1; a_req_is_store = 1; a_req_size = 1; a_req_addr = 64'h1006;
    a_req_wdata = 64'hABCD; a_mem_req_ready = 0;
    tick;
    a_req_valid = 0;
    chk("sh_mreq_valid", a_mem_req_valid, 1);
    chk("sh_we", a_mem_req_we, 1);
    chk("sh_maddr", a_mem_req_addr, 64'h1000);
    chk("sh_wdata", a_mem_req_wdata, 64'hABCD_0000_0000_0000);
    chk("sh_wmask", a_mem_req_wmask, 8'hC0);
    a_mem_req_ready = 1;
    tick;
    a_mem_req_ready = 0; a_mem_rsp_valid = 1; a_mem_rsp_rdata = 64'h1234_5678;
    tick;
    a_mem_rsp_valid = 0;
    chk("sh_rsp_valid", a_rsp_valid, 1);
    chk("sh_rsp_data", a_rsp_data, 0);
    chk("sh_rsp_err", a_rsp_err, 0);
    tick;

    // Misaligned word: error straight away, no bus request
    a_req_valid = 1; a_req_is_store = 0; a_req_size = 2; a_req_addr = 64'h1002;
    tick;
    a_req_valid = 0;
    chk("mis_rsp_valid", a_rsp_valid, 1);
    chk("mis_rsp_err", a_rsp_err, 1);
    chk("mis_rsp_data", a_rsp_data, 0);
    chk("mis_mreq_valid", a_mem_req_valid, 0);
    tick;
    chk("mis_idle_mreq_valid", a_mem_req_valid, 0);
    chk("mis_idle_req_ready", a_req_ready, 1);

    // Backpressure on both interfaces
    hs_mem0 = a_mem_hs; hs_rsp0 = a_rsp_hs;
    a_req_valid = 1; a_req_is_store = 1; a_req_size = 2; a_req_addr = 64'h2004;
    a_req_wdata = 64'h1122_3344; a_mem_req_ready = 0;
    tick;
    a_req_valid = 0; a_req_wdata = 64'hFFFF_FFFF; a_req_addr = 64'h0;
    for (int i = 0; i < 5; i++) begin
      chk("bp_mreq_valid", a_mem_req_valid, 1);
      chk("bp_maddr", a_mem_req_addr, 64'h2000);
      chk("bp_wdata", a_mem_req_wdata, 64'h1122_3344_0000_0000);
      chk("bp_wmask", a_mem_req_wmask, 8'hF0);
      tick;
    end
    chk("bp_mreq_valid_last", a_mem_req_valid, 1);
    a_mem_req_ready = 1;
    tick;
    a_mem_req_ready = 0; a_rsp_ready = 0; a_mem_rsp_valid = 1;
    tick;
    a_mem_rsp_valid = 0;
    for (int i = 0; i < 3; i++) begin
      chk("bp_rsp_valid", a_rsp_valid, 1);
      chk("bp_rsp_data", a_rsp_data, 0);
      chk("bp_rsp_err", a_rsp_err, 0);
      tick;
    end
    chk("bp_rsp_valid_last", a_rsp_valid, 1);
    a_rsp_ready = 1;
    tick;
    chk("bp_rsp_done", a_rsp_valid, 0);
    chk("bp_mem_hs", 64'(a_mem_hs - hs_mem0), 1);
    chk("bp_rsp_hs", 64'(a_rsp_hs - hs_rsp0), 1);

    // 32-bit instance: byte load, timeout, illegal size
    b_req_valid = 1; b_req_size = 0; b_req_addr = 32'h3; b_mem_req_ready = 1;
    tick;
    b_req_valid = 0;
    chk("b_lb_maddr", b_mem_req_addr, 32'h0);
    tick;
    b_mem_req_ready = 0; b_mem_rsp_valid = 1; b_mem_rsp_rdata = 32'h8000_0000;
    tick;
    b_mem_rsp_valid = 0;
    chk("b_lb_vld", b_rsp_valid, 1);
    chk("b_lb_data", b_rsp_data, 32'hFFFF_FF80);
    tick;

    b_req_valid = 1; b_req_size = 2; b_req_addr = 32'h40; b_mem_req_ready = 1;
    tick;
    b_req_valid = 0;
    tick;
    b_mem_req_ready = 0;
    for (int i = 0; i < 3; i++) begin
      tick;
      chk("b_to_early_vld", b_rsp_valid, 0);
    end
    tick;
    chk("b_to_vld", b_rsp_valid, 1);
    chk("b_to_err", b_rsp_err, 1);
    chk("b_to_data", b_rsp_data, 0);
    tick;

    b_req_valid = 1; b_req_size = 3; b_req_addr = 32'h0;
    tick;
    b_req_valid = 0;
    chk("b_sz3_vld", b_rsp_valid, 1);
    chk("b_sz3_err", b_rsp_err, 1);
    chk("b_sz3_mreq_valid", b_mem_req_valid, 0);
    tick;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
